cla_adder: RTL and testbench

Registered carry-lookahead adder. Adds two unsigned WIDTH-bit operands plus a carry-in using two-level lookahead (4-bit groups), and registers the sum and carry-out on the rising clock edge. It serves as the datapath adder primitive in the components library and replaces ripple-carry adders where the carry path is timing-critical.

---
 rtl/cla_adder_pkg.sv | 5 +
 rtl/cla_group4.sv | 33 +++
 rtl/cla_adder.sv | 64 ++++++
 tb/tb_cla_adder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cla_adder_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package cla_adder_pkg;
  localparam int WIDTH_DEFAULT = 8;
  localparam int CLA_GROUP     = 4;
endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: internal carries from cin, plus group generate/propagate.
module cla_group4
  import cla_adder_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 G,
  output logic                 P
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products of cin, g and p; nothing ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign s = p ^ c;

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: {OutputCarry, Sum} <= InputA + InputB + InputCarry.
module cla_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputCarry,
  output logic [WIDTH-1:0] Sum,
  output logic             OutputCarry
);

  localparam int NG = WIDTH / CLA_GROUP;

  // No handshake: the output register loads a fresh result on every rising edge.
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] sum_next;

  assign grp_c[0] = InputCarry;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic carry_out;
    logic term;

    cla_group4 u_group (
      .a   (InputA[gi*CLA_GROUP +: CLA_GROUP]),
      .b   (InputB[gi*CLA_GROUP +: CLA_GROUP]),
      .cin (grp_c[gi]),
      .s   (sum_next[gi*CLA_GROUP +: CLA_GROUP]),
      .G   (grp_g[gi]),
      .P   (grp_p[gi])
    );

    // Carry out of group gi as a flat OR of products over all lower groups and InputCarry.
    always_comb begin
      term      = 1'b0;
      carry_out = InputCarry;
      for (int m = 0; m <= gi; m++) carry_out = carry_out & grp_p[m];
      for (int j = 0; j <= gi; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= gi; m++) term = term & grp_p[m];
        carry_out = carry_out | term;
      end
    end

    assign grp_c[gi+1] = carry_out;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Sum         <= '0;
      OutputCarry <= 1'b0;
    end else begin
      Sum         <= sum_next;
      OutputCarry <= grp_c[NG];
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: directed reset/hold cases, then random vectors vs A+B+Cin.
module tb_cla_adder;
  import cla_adder_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         InputCarry;
  logic [W-1:0] Sum;
  logic         OutputCarry;

  logic [W:0] exp_q[$];
  int n_cmp;
  int n_bad;

  cla_adder #(.WIDTH(W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InputA      (InputA),
    .InputB      (InputB),
    .InputCarry  (InputCarry),
    .Sum         (Sum),
    .OutputCarry (OutputCarry)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: plain wide arithmetic.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return total[W:0];
  endfunction

  function automatic void check(input string name, input logic [W:0] got,
                                input logic [W:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
               name, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endfunction

  // Driver: inputs are set away from the edge; the expected result is queued at the
  // edge that samples them.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    InputA     = a;
    InputB     = b;
    InputCarry = c;
    @(posedge Clock);
    exp_q.push_back(ref_sum(a, b, c));
    #2;
  endtask

  // Monitor: outputs are sampled on the falling edge, one per queued expectation.
  always @(negedge Clock) begin
    if (Reset && exp_q.size() > 0) begin
      check("scoreboard", {OutputCarry, Sum}, exp_q.pop_front());
    end
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    Reset      = 1'b0;
    InputA     = 8'd5;
    InputB     = 8'd12;
    InputCarry = 1'b0;

    // Reset held low with clock running: outputs stay zero.
    #1;
    check("reset_initial", {OutputCarry, Sum}, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #2;
      check("reset_held", {OutputCarry, Sum}, '0);
    end

    @(negedge Clock);
    Reset = 1'b1;
    #2;

    drive(8'd5, 8'd12, 1'b0);

    // Mid-cycle asynchronous reset after the 17 result is registered.
    #4;
    check("pre_async_reset", {OutputCarry, Sum}, ref_sum(8'd5, 8'd12, 1'b0));
    Reset = 1'b0;
    #1;
    check("async_reset_clear", {OutputCarry, Sum}, '0);
    @(negedge Clock);
    Reset = 1'b1;
    #2;

    drive(8'hFF, 8'h01, 1'b0);
    drive(8'h0F, 8'hF0, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1);
    drive(8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1);

    // Input changes between edges must not reach the outputs.
    InputA     = 8'd3;
    InputB     = 8'd4;
    InputCarry = 1'b0;
    #2;
    check("hold_first_change", {OutputCarry, Sum}, 9'h1FF);
    InputA = 8'd100;
    InputB = 8'd27;
    #2;
    check("hold_second_change", {OutputCarry, Sum}, 9'h1FF);
    drive(8'd100, 8'd27, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge Clock);
    #6;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
